window_filter_stream: RTL and testbench

- Streaming 3x3 sliding-window image filter; parametrised successor to the fixed 8-bit, memory-driven 3x3 filter top.
- Accepts one raster-order pixel per handshake and builds the window internally from two line buffers.
- Filter mode is selectable per frame; results leave on a valid/ready output with backpressure.
- Sits between the pixel source and the frame writer in the image pipeline.

---
 rtl/window_filter_stream.sv | 157 +++++++++++++++
 tb/tb_window_filter_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/window_filter_stream.sv
// Streaming 3x3 window filter (bypass / gaussian / sharpen / max) with two line buffers.
// Optional WINDOW_FILTER_SAT_CNT_EN adds sat_cnt, a count of clamped sharpen beats taken downstream.
module window_filter_stream #(
  parameter int PW    = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pixel,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pixel,
  output logic          out_eof,
`ifdef WINDOW_FILTER_SAT_CNT_EN
  output logic [15:0]   sat_cnt,
`endif
  output logic          frame_busy
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int XW = PW + 4;

  logic          adv, accept, first, take;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    mode_q, win_mode;
  logic          win_eof, s1_eof;
  logic [2:0]    vld_pipe;
  logic [PW-1:0] s1_pix;
  logic [2:0][2:0][PW-1:0] win;  // win[r][c], r=0 is oldest row (r-2)
  logic [PW-1:0] lb1 [IMG_W];
  logic [PW-1:0] lb2 [IMG_W];

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && rst_n;
  assign accept    = in_valid && in_ready;
  assign first     = (row == '0) && (col == '0);
  assign take      = out_valid && out_ready;
  assign out_valid = vld_pipe[2];

  // Kernel datapath on the current window
  logic [PW-1:0] c, n, s, e, w, mx, k_pix;
  logic [XW-1:0] g_sum, orth, sh_u;
  logic          k_sat;

  always_comb begin
    c = win[1][1]; n = win[0][1]; s = win[2][1]; w = win[1][0]; e = win[1][2];
    orth  = XW'(n) + XW'(s) + XW'(e) + XW'(w);
    g_sum = XW'(win[0][0]) + XW'(win[0][2]) + XW'(win[2][0]) + XW'(win[2][2])
          + (orth << 1) + (XW'(c) << 2) + XW'(8);
    // 5c fits below 2^(PW+3), so the MSB is a valid sign bit
    sh_u  = (XW'(c) << 2) + XW'(c) - orth;
    mx = win[0][0];
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++)
        if (win[r][q] > mx) mx = win[r][q];
    k_sat = 1'b0;
    case (win_mode)
      2'b01: k_pix = PW'(g_sum >> 4);
      2'b10: begin
        if (sh_u[XW-1]) begin
          k_pix = '0; k_sat = 1'b1;
        end else if (|sh_u[XW-2:PW]) begin
          k_pix = '1; k_sat = 1'b1;
        end else begin
          k_pix = sh_u[PW-1:0];
        end
      end
      2'b11:   k_pix = mx;
      default: k_pix = c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= in_pixel;
      lb2[col] <= lb1[col];
    end
  end

`ifdef WINDOW_FILTER_SAT_CNT_EN
  logic s1_sat, out_sat;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sat  <= 1'b0;
      out_sat <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (adv) begin
        s1_sat  <= k_sat && vld_pipe[0];
        out_sat <= s1_sat;
      end
      if (accept && first)
        sat_cnt <= '0;
      else if (take && out_sat && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = k_sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      mode_q     <= '0;
      win_mode   <= '0;
      win_eof    <= 1'b0;
      win        <= '0;
      vld_pipe   <= '0;
      s1_pix     <= '0;
      s1_eof     <= 1'b0;
      out_pixel  <= '0;
      out_eof    <= 1'b0;
      frame_busy <= 1'b0;
    end else begin
      if (accept) begin
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H-1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (first) mode_q <= mode;
        win_mode <= first ? mode : mode_q;
        win_eof  <= (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2[col];
        win[1][2] <= lb1[col];
        win[2][2] <= in_pixel;
      end
      if (adv) begin
        vld_pipe[0] <= accept && (row >= RW'(2)) && (col >= CW'(2));
        vld_pipe[1] <= vld_pipe[0];
        vld_pipe[2] <= vld_pipe[1];
        s1_pix      <= k_pix;
        s1_eof      <= win_eof && vld_pipe[0];
        out_pixel   <= s1_pix;
        out_eof     <= s1_eof && vld_pipe[1];
      end
      // A new frame starting wins over the previous frame's eof beat
      if (accept && first)
        frame_busy <= 1'b1;
      else if (take && out_eof)
        frame_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_window_filter_stream.sv
// Scoreboard bench for window_filter_stream on a 4x4 image: directed frames, expected outputs hand-computed.
module tb_window_filter_stream;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_eof, frame_busy;
  logic [7:0] in_pixel, out_pixel;
  logic [1:0] mode;
`ifdef WINDOW_FILTER_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  window_filter_stream #(.PW(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_eof(out_eof),
`ifdef WINDOW_FILTER_SAT_CNT_EN
    .sat_cnt(sat_cnt),
`endif
    .frame_busy(frame_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] pix; logic eof; } exp_t;
  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] img [16];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops and compares on every output handshake
  initial begin
    exp_t x;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", int'(out_pixel), -1);
        end else begin
          x = q.pop_front();
          chk("out_pixel", int'(out_pixel), int'(x.pix));
          chk("out_eof", int'(out_eof), int'(x.eof));
        end
      end
    end
  end

  task automatic push4(input int a, input int b, input int c, input int d);
    q.push_back({8'(a), 1'b0}); q.push_back({8'(b), 1'b0});
    q.push_back({8'(c), 1'b0}); q.push_back({8'(d), 1'b1});
  endtask

  task automatic send_px(input logic [7:0] p);
    int n = 0;
    @(negedge clk); in_valid = 1'b1; in_pixel = p; #1;
    while (!in_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic send_frame(input int npx, input logic [1:0] m, input int sw_at, input logic [1:0] m2);
    mode = m;
    for (int i = 0; i < npx; i++) begin
      if (i == sw_at) mode = m2;
      send_px(img[i]);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk(nm, q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) img[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1; mode = 2'b00;
    repeat (3) @(negedge clk);
    #1 chk("in_ready_in_reset", int'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_out_eof", int'(out_eof), 0);
    chk("rst_frame_busy", int'(frame_busy), 0);

    // Gaussian on a flat 100 image
    fill(8'd100);
    push4(100, 100, 100, 100);
    send_frame(16, 2'b01, -1, 2'b01);
    chk("busy_during_frame", int'(frame_busy), 1);
    drain("gauss_drain");
    chk("busy_after_eof", int'(frame_busy), 0);

    // Sharpen: both clamp directions
    fill(8'd0);
    img[5] = 8'd255; img[6] = 8'd200; img[9] = 8'd200; img[11] = 8'd200; img[14] = 8'd200;
    push4(255, 255, 255, 0);
    send_frame(16, 2'b10, -1, 2'b10);
    drain("sharpen_drain");
`ifdef WINDOW_FILTER_SAT_CNT_EN
    chk("sat_cnt_sharpen", int'(sat_cnt), 4);
`endif

    // Max with a single corner pixel
    fill(8'd0); img[0] = 8'd77;
    push4(77, 0, 0, 0);
    send_frame(16, 2'b11, -1, 2'b11);
    drain("max_drain");
`ifdef WINDOW_FILTER_SAT_CNT_EN
    chk("sat_cnt_cleared", int'(sat_cnt), 0);
`endif

    // Backpressure: ramp image in bypass, output stalled then released
    for (int i = 0; i < 16; i++) img[i] = 8'(i + 1);
    push4(6, 7, 10, 11);
    @(negedge clk); out_ready = 1'b0;
    fork
      send_frame(16, 2'b00, -1, 2'b00);
      begin
        int n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk); #1; n++;
        end
        chk("bp_out_valid", int'(out_valid), 1);
        repeat (5) @(negedge clk);
        #1;
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_pixel_held", int'(out_pixel), 6);
        chk("bp_valid_held", int'(out_valid), 1);
        @(negedge clk); out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Mode change mid-frame stays bypass; next frame is gaussian
    fill(8'd0); img[5] = 8'd160;
    push4(160, 0, 0, 0);
    send_frame(16, 2'b00, 3, 2'b01);
    drain("modesw_drain1");
    push4(40, 20, 20, 10);
    send_frame(16, 2'b01, -1, 2'b01);
    drain("modesw_drain2");

    // Reset mid-frame after 7 accepted pixels
    fill(8'd100);
    send_frame(7, 2'b01, -1, 2'b01);
    chk("busy_before_reset", int'(frame_busy), 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("in_ready_mid_reset", int'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("reset_busy", int'(frame_busy), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    push4(100, 100, 100, 100);
    send_frame(16, 2'b01, -1, 2'b01);
    drain("post_reset_drain");
    chk("post_reset_busy", int'(frame_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
